// File: rtl/sng_pkg.sv
// sng_pkg: shared FSM state encoding and LFSR tap table for the stochastic number generator
//   IDLE/GEN/DONE state enum, legal LFSR width range, and tap masks indexed by width.
package sng_pkg;
   typedef enum logic [1:0] {IDLE, GEN, DONE} sng_state_t;
   localparam int MIN_BIT = 4;
   localparam int MAX_BIT = 16;
   // Maximal-length Fibonacci taps: bit k-1 set for polynomial term x^k (8-bit: x^8+x^6+x^5+x^4+1)
   localparam logic [15:0] TAP_TABLE [MIN_BIT:MAX_BIT] = '{
      16'h000C, 16'h0014, 16'h0030, 16'h0060, 16'h00B8, 16'h0110, 16'h0240,
      16'h0500, 16'h0829, 16'h100D, 16'h2015, 16'h6000, 16'hD008};
   function automatic logic [15:0] tap_mask(input int n);
      return TAP_TABLE[n];
   endfunction
endpackage

// File: rtl/sn_gen_if.sv
// sn_gen_if: request/stream bundle between a stream requester (master) and sn_gen (slave)
//   i_start_sng, i_bipolar, i_x_bn, i_len, i_seed : request side
//   o_isgen, o_sn_bit, o_done, o_busy             : stream/status side
interface sn_gen_if #(
   parameter int DIM     = 256,
   parameter int NUM_BIT = 8
);
   logic                            i_start_sng;
   logic                            i_bipolar;
   logic [DIM-1:0][NUM_BIT-1:0]     i_x_bn;
   logic [NUM_BIT-1:0]              i_len;
   logic [NUM_BIT-1:0]              i_seed;
   logic                            o_isgen;
   logic [DIM-1:0]                  o_sn_bit;
   logic                            o_done;
   logic                            o_busy;
   modport master (
      output i_start_sng, i_bipolar, i_x_bn, i_len, i_seed,
      input  o_isgen, o_sn_bit, o_done, o_busy
   );
   modport slave (
      input  i_start_sng, i_bipolar, i_x_bn, i_len, i_seed,
      output o_isgen, o_sn_bit, o_done, o_busy
   );
endinterface

// File: rtl/sn_lfsr.sv
// sn_lfsr: shared Fibonacci LFSR with seed load (zero seed replaced by all-ones) and step enable
//   clk_i, rst_ni : clock, async active-low reset (state resets to all-ones)
//   load_i, seed_i: load seed; en_i: advance one step
//   nxt_o         : next-state value, so callers can register results aligned with the LFSR
module sn_lfsr import sng_pkg::*; #(
   parameter int NUM_BIT = 8
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic               load_i,
   input  logic               en_i,
   input  logic [NUM_BIT-1:0] seed_i,
   output logic [NUM_BIT-1:0] nxt_o
);
   localparam logic [15:0]        TAPS16 = tap_mask(NUM_BIT);
   localparam logic [NUM_BIT-1:0] TAPS   = TAPS16[NUM_BIT-1:0];
   logic [NUM_BIT-1:0] lfsr_q, lfsr_d;
   always_comb begin
      lfsr_d = load_i ? ((seed_i == '0) ? '1 : seed_i)
             : en_i   ? {lfsr_q[NUM_BIT-2:0], ^(lfsr_q & TAPS)}
             :          lfsr_q;
   end
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) lfsr_q <= '1;
      else         lfsr_q <= lfsr_d;
   end
   assign nxt_o = lfsr_d;
endmodule

// File: rtl/sn_gen.sv
// sn_gen: DIM-lane stochastic number generator driven by one shared LFSR
//   i_clk_sng : clock
//   i_rst_sng : async active-low reset
//   bus       : sn_gen_if slave (start/bipolar/operands/len/seed in; isgen/sn_bit/done/busy out)
module sn_gen import sng_pkg::*; #(
   parameter int DIM     = 256,
   parameter int NUM_BIT = 8
) (
   input  logic    i_clk_sng,
   input  logic    i_rst_sng,
   sn_gen_if.slave bus
);
   if (NUM_BIT < MIN_BIT || NUM_BIT > MAX_BIT) begin : g_bad_width
      $error("sn_gen: NUM_BIT out of range");
   end
   sng_state_t                  state_q, state_d;
   logic [NUM_BIT-1:0]          cnt_q, cnt_d, lfsr_d;
   logic [DIM-1:0][NUM_BIT-1:0] x_q, x_d;
   logic                        bip_q, bip_d, start_ok;
   logic [DIM-1:0]              sn_q, sn_d;

   assign start_ok = (state_q == IDLE) && bus.i_start_sng;

   sn_lfsr #(.NUM_BIT(NUM_BIT)) u_lfsr (
      .clk_i  (i_clk_sng),
      .rst_ni (i_rst_sng),
      .load_i (start_ok),
      .en_i   (state_q == GEN),
      .seed_i (bus.i_seed),
      .nxt_o  (lfsr_d)
   );

   always_ff @(posedge i_clk_sng or negedge i_rst_sng) begin
      if (!i_rst_sng) state_q <= IDLE;
      else            state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (start_ok)                                  state_d = (bus.i_len != '0) ? GEN : DONE;
      else if (state_q == GEN && cnt_q == NUM_BIT'(1)) state_d = DONE;
      else if (state_q == DONE)                      state_d = IDLE;
   end

   always_comb begin
      bus.o_isgen  = state_q == GEN;
      bus.o_done   = state_q == DONE;
      bus.o_busy   = state_q != IDLE;
      bus.o_sn_bit = sn_q;
   end

   always_comb begin
      cnt_d = start_ok ? bus.i_len : (state_q == GEN) ? cnt_q - 1'b1 : cnt_q;
      x_d   = start_ok ? bus.i_x_bn : x_q;
      bip_d = start_ok ? bus.i_bipolar : bip_q;
   end

   // Bits are computed from next-state values so the registered lane bit lines up with o_isgen.
   // The LFSR never yields zero, so xo >= r gives exactly xo ones over a full period.
   for (genvar i = 0; i < DIM; i++) begin : g_lane
      logic [NUM_BIT-1:0]   xo;
      logic [2*NUM_BIT-1:0] rr;
      assign xo      = {x_d[i][NUM_BIT-1] ^ bip_d, x_d[i][NUM_BIT-2:0]};
      assign rr      = {lfsr_d, lfsr_d} << (i % NUM_BIT);
      assign sn_d[i] = (state_d == GEN) && (xo >= rr[2*NUM_BIT-1:NUM_BIT]);
   end

   always_ff @(posedge i_clk_sng or negedge i_rst_sng) begin
      if (!i_rst_sng) begin
         cnt_q <= '0;
         x_q   <= '0;
         bip_q <= 1'b0;
         sn_q  <= '0;
      end else begin
         cnt_q <= cnt_d;
         x_q   <= x_d;
         bip_q <= bip_d;
         sn_q  <= sn_d;
      end
   end
endmodule

// File: tb/tb_sn_gen.sv
// tb_sn_gen: randomized self-checking bench for sn_gen against a bit-stream LFSR model
module tb_sn_gen;
   localparam int DIM = 8;
   localparam int NB  = 8;
   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int total = 0;
   int bad   = 0;
   logic [NB-1:0]  xv [DIM];
   logic [DIM-1:0] o_sn [$];
   logic           o_gen [$];
   logic           o_done [$];
   logic           o_busy [$];
   logic [3:0]     post;

   always #5 clk = ~clk;

   sn_gen_if #(.DIM(DIM), .NUM_BIT(NB)) bus ();
   sn_gen #(.DIM(DIM), .NUM_BIT(NB)) dut (.i_clk_sng(clk), .i_rst_sng(rst_n), .bus(bus));

   // Register value after k steps, taken as an 8-bit window over the recurrence
   // b[n+8] = b[n]^b[n+2]^b[n+3]^b[n+4] (taps x^8,x^6,x^5,x^4); lane l compares against it rotated by l.
   function automatic logic [DIM-1:0] exp_sn(input logic bip, input logic [NB-1:0] seed, input int k);
      bit b [$];
      int r, s, rot, xo;
      logic [DIM-1:0] v;
      for (int i = NB - 1; i >= 0; i--) b.push_back(seed[i]);
      for (int n = 0; n < k; n++) b.push_back(b[n] ^ b[n+2] ^ b[n+3] ^ b[n+4]);
      r = 0;
      for (int i = 0; i < NB; i++) r = r * 2 + int'(b[k+i]);
      for (int l = 0; l < DIM; l++) begin
         s   = l % NB;
         rot = ((r << s) | (r >> (NB - s))) % (1 << NB);
         xo  = bip ? (int'(xv[l]) + 128) % 256 : int'(xv[l]);
         v[l] = xo >= rot;
      end
      return v;
   endfunction

   task automatic run_stream(input logic bip, input logic [NB-1:0] len, input logic [NB-1:0] seed);
      o_sn.delete(); o_gen.delete(); o_done.delete(); o_busy.delete();
      for (int i = 0; i < DIM; i++) bus.i_x_bn[i] = xv[i];
      bus.i_bipolar = bip; bus.i_len = len; bus.i_seed = seed; bus.i_start_sng = 1'b1;
      @(posedge clk); #1;
      bus.i_start_sng = 1'b0;
      for (int c = 0; c < 300; c++) begin
         o_sn.push_back(bus.o_sn_bit); o_gen.push_back(bus.o_isgen);
         o_done.push_back(bus.o_done); o_busy.push_back(bus.o_busy);
         if (bus.o_done) break;
         @(posedge clk); #1;
      end
      @(posedge clk); #1;
      post = {bus.o_isgen, bus.o_done, bus.o_busy, |bus.o_sn_bit};
   endtask

   task automatic test_reset();
      bus.i_start_sng = 1'b1; bus.i_bipolar = 1'b0; bus.i_x_bn = '1; bus.i_len = 8'd5; bus.i_seed = 8'h11;
      repeat (2) @(posedge clk);
      #1;
      total++; if (bus.o_isgen !== 1'b0) begin bad++; $display("FAIL reset_isgen: got %b want 0", bus.o_isgen); end
      total++; if (bus.o_done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", bus.o_done); end
      total++; if (bus.o_busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", bus.o_busy); end
      total++; if (bus.o_sn_bit !== '0) begin bad++; $display("FAIL reset_sn: got %h want 0", bus.o_sn_bit); end
      bus.i_start_sng = 1'b0;
      rst_n = 1'b1;
   endtask

   task automatic test_full_period(input logic bip);
      int gen, dn, ones, want;
      xv[0] = bip ? 8'h00 : 8'h80; xv[1] = bip ? 8'h7F : 8'h00; xv[2] = bip ? 8'h80 : 8'hFF;
      for (int i = 3; i < DIM; i++) xv[i] = NB'($urandom);
      run_stream(bip, 8'd255, bip ? NB'($urandom) : 8'h5A);
      gen = 0; dn = 0;
      foreach (o_gen[c]) begin gen += int'(o_gen[c]); dn += int'(o_done[c]); end
      total++;
      if (gen !== 255 || o_gen[0] !== 1'b1) begin bad++; $display("FAIL period_isgen bip=%b: got %0d cycles first=%b want 255 first=1", bip, gen, o_gen[0]); end
      total++;
      if (dn !== 1 || post !== 4'b0) begin bad++; $display("FAIL period_done bip=%b: got pulses=%0d post=%b want 1 and 0000", bip, dn, post); end
      for (int l = 0; l < DIM; l++) begin
         ones = 0;
         foreach (o_sn[c]) ones += int'(o_sn[c][l]);
         want = bip ? (int'(xv[l]) + 128) % 256 : int'(xv[l]);
         total++;
         if (ones !== want) begin bad++; $display("FAIL period_ones bip=%b lane=%0d: got %0d want %0d", bip, l, ones, want); end
      end
   endtask

   task automatic test_random();
      logic bip;
      logic [NB-1:0] len, seed, seff;
      for (int t = 0; t < 8; t++) begin
         for (int i = 0; i < DIM; i++) xv[i] = NB'($urandom);
         bip = 1'($urandom); len = NB'($urandom_range(1, 40)); seed = NB'($urandom);
         seff = (seed == '0) ? 8'hFF : seed;
         run_stream(bip, len, seed);
         total++;
         if (o_sn.size() !== int'(len) + 1) begin
            bad++; $display("FAIL rand_len t=%0d: got %0d cycles want %0d", t, o_sn.size(), int'(len) + 1);
            continue;
         end
         for (int k = 0; k < int'(len); k++) begin
            total++;
            if ({o_gen[k], o_done[k], o_sn[k]} !== {1'b1, 1'b0, exp_sn(bip, seff, k)}) begin
               bad++; $display("FAIL rand_bits t=%0d k=%0d: got gen=%b done=%b sn=%h want 1 0 %h", t, k, o_gen[k], o_done[k], o_sn[k], exp_sn(bip, seff, k));
            end
         end
         total++;
         if ({o_gen[len], o_done[len], o_busy[len], o_sn[len], post} !== {3'b011, {DIM{1'b0}}, 4'b0000}) begin
            bad++; $display("FAIL rand_end t=%0d: got gen=%b done=%b busy=%b sn=%h post=%b want 0 1 1 0 0000", t, o_gen[len], o_done[len], o_busy[len], o_sn[len], post);
         end
      end
   endtask

   task automatic test_len_zero();
      for (int i = 0; i < DIM; i++) xv[i] = NB'($urandom);
      run_stream(1'($urandom), 8'd0, NB'($urandom));
      total++;
      if (o_sn.size() !== 1) begin bad++; $display("FAIL len0_cycles: got %0d want 1", o_sn.size()); end
      total++;
      if ({o_gen[0], o_done[0], o_busy[0], o_sn[0]} !== {3'b011, {DIM{1'b0}}}) begin
         bad++; $display("FAIL len0_done: got gen=%b done=%b busy=%b sn=%h want 0 1 1 0", o_gen[0], o_done[0], o_busy[0], o_sn[0]);
      end
      total++;
      if (post !== 4'b0) begin bad++; $display("FAIL len0_idle: got %b want 0000", post); end
   endtask

   task automatic test_back_to_back();
      logic bip;
      logic [NB-1:0] s;
      logic [DIM+2:0] got, want;
      for (int i = 0; i < DIM; i++) xv[i] = NB'($urandom);
      bip = 1'($urandom); s = NB'($urandom_range(1, 255));
      for (int i = 0; i < DIM; i++) bus.i_x_bn[i] = xv[i];
      bus.i_bipolar = bip; bus.i_len = 8'd3; bus.i_seed = s; bus.i_start_sng = 1'b1;
      for (int c = 0; c < 10; c++) begin
         @(posedge clk); #1;
         got  = {bus.o_isgen, bus.o_done, bus.o_busy, bus.o_sn_bit};
         want = (c % 5 < 3) ? {3'b101, exp_sn(bip, s, c % 5)} : (c % 5 == 3) ? {3'b011, {DIM{1'b0}}} : '0;
         total++;
         if (got !== want) begin bad++; $display("FAIL b2b c=%0d: got %h want %h", c, got, want); end
      end
      bus.i_start_sng = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_seed_zero();
      logic bip;
      for (int i = 0; i < DIM; i++) xv[i] = NB'($urandom);
      bip = 1'($urandom);
      run_stream(bip, 8'd255, 8'h00);
      total++;
      if (o_sn.size() !== 256) begin
         bad++; $display("FAIL seed0_cycles: got %0d want 256", o_sn.size());
      end else begin
         for (int k = 0; k < 255; k++) begin
            total++;
            if (o_sn[k] !== exp_sn(bip, 8'hFF, k)) begin bad++; $display("FAIL seed0_bits k=%0d: got %h want %h", k, o_sn[k], exp_sn(bip, 8'hFF, k)); end
         end
      end
   endtask

   task automatic test_reset_mid();
      logic seen;
      logic [NB-1:0] s;
      for (int i = 0; i < DIM; i++) xv[i] = NB'($urandom);
      for (int i = 0; i < DIM; i++) bus.i_x_bn[i] = xv[i];
      bus.i_bipolar = 1'b0; bus.i_len = 8'd100; bus.i_seed = 8'h3C; bus.i_start_sng = 1'b1;
      @(posedge clk); #1;
      bus.i_start_sng = 1'b0;
      repeat (9) begin @(posedge clk); #1; end
      total++;
      if (bus.o_isgen !== 1'b1) begin bad++; $display("FAIL mid_pre: got isgen=%b want 1", bus.o_isgen); end
      #2 rst_n = 1'b0;
      #1;
      total++;
      if ({bus.o_isgen, bus.o_done, bus.o_busy, bus.o_sn_bit} !== '0) begin
         bad++; $display("FAIL mid_async: got gen=%b done=%b busy=%b sn=%h want all 0", bus.o_isgen, bus.o_done, bus.o_busy, bus.o_sn_bit);
      end
      seen = 1'b0;
      repeat (3) begin @(posedge clk); #1; seen |= bus.o_done | bus.o_busy; end
      rst_n = 1'b1;
      repeat (2) begin @(posedge clk); #1; seen |= bus.o_done | bus.o_busy; end
      total++;
      if (seen !== 1'b0) begin bad++; $display("FAIL mid_nodone: got done/busy activity=%b want 0", seen); end
      s = NB'($urandom_range(1, 255));
      run_stream(1'b1, 8'd5, s);
      total++;
      if (o_sn.size() !== 6) begin
         bad++; $display("FAIL mid_restart_len: got %0d want 6", o_sn.size());
      end else begin
         for (int k = 0; k < 5; k++) begin
            total++;
            if ({o_gen[k], o_sn[k]} !== {1'b1, exp_sn(1'b1, s, k)}) begin
               bad++; $display("FAIL mid_restart k=%0d: got gen=%b sn=%h want 1 %h", k, o_gen[k], o_sn[k], exp_sn(1'b1, s, k));
            end
         end
         total++;
         if ({o_done[5], post} !== 5'b10000) begin bad++; $display("FAIL mid_restart_end: got done=%b post=%b want 1 0000", o_done[5], post); end
      end
   endtask

   initial begin
      test_reset();
      test_full_period(1'b0);
      test_full_period(1'b1);
      test_random();
      test_len_zero();
      test_back_to_back();
      test_seed_zero();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end
endmodule
